// File: rtl/lcd_controller.sv
// HD44780-style character LCD sequencer: power-up wait, fixed 8-bit init, then
// single command/data byte writes with E setup/pulse/hold and execution waits.
module lcd_controller #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 3,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int HOLD_CYCLES       = 1,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    // Handshake: a byte is taken on a rising edge where i_wr_valid & o_wr_ready;
    // o_wr_ready drops on that edge, and i_wr_valid while not ready is ignored.
    input  logic       i_wr_valid,
    input  logic       i_wr_rs,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    output logic       o_init_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_data,
    output logic [2:0] o_state
);
    localparam int M1      = (POWERUP_CYCLES > SETUP_CYCLES) ? POWERUP_CYCLES : SETUP_CYCLES;
    localparam int M2      = (M1 > E_PULSE_CYCLES) ? M1 : E_PULSE_CYCLES;
    localparam int M3      = (M2 > HOLD_CYCLES) ? M2 : HOLD_CYCLES;
    localparam int M4      = (M3 > CMD_WAIT_CYCLES) ? M3 : CMD_WAIT_CYCLES;
    localparam int MAX_CYC = (M4 > CLEAR_WAIT_CYCLES) ? M4 : CLEAR_WAIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_IDLE    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_limit;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic               r_rs, w_rs_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_e, w_e_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_done, w_done_nxt;
    logic               w_last;
    logic               w_is_clear;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            default:          init_rom = 8'h06;
        endcase
    endfunction

    // Clear (01) and home (02/03) need the long execution wait.
    assign w_is_clear = !r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);

    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_POWERUP: w_limit = CNT_W'(POWERUP_CYCLES - 1);
            ST_SETUP:   w_limit = CNT_W'(SETUP_CYCLES - 1);
            ST_PULSE:   w_limit = CNT_W'(E_PULSE_CYCLES - 1);
            ST_HOLD:    w_limit = CNT_W'(HOLD_CYCLES - 1);
            ST_WAIT:    w_limit = w_is_clear ? CNT_W'(CLEAR_WAIT_CYCLES - 1)
                                             : CNT_W'(CMD_WAIT_CYCLES - 1);
            default:    w_limit = '0;
        endcase
    end

    assign w_last = (r_cnt == w_limit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_POWERUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_e     <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rs    <= w_rs_nxt;
            r_data  <= w_data_nxt;
            r_e     <= w_e_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_POWERUP: if (w_last) w_next_state = ST_SETUP;
            ST_SETUP:   if (w_last) w_next_state = ST_PULSE;
            ST_PULSE:   if (w_last) w_next_state = ST_HOLD;
            ST_HOLD:    if (w_last) w_next_state = ST_WAIT;
            ST_WAIT:    if (w_last) w_next_state = (r_done || r_idx == INIT_LAST) ? ST_IDLE : ST_SETUP;
            ST_IDLE:    if (i_wr_valid && r_ready) w_next_state = ST_SETUP;
            default:    w_next_state = ST_POWERUP;
        endcase
    end

    // Next values of the registered outputs; every state entry restarts the counter.
    always_comb begin
        w_cnt_nxt   = (w_next_state != r_state || r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        if (r_state == ST_POWERUP && w_last) begin
            w_idx_nxt  = 3'd0;
            w_rs_nxt   = 1'b0;
            w_data_nxt = init_rom(3'd0);
        end else if (r_state == ST_WAIT && w_next_state == ST_SETUP) begin
            w_idx_nxt  = r_idx + 3'd1;
            w_rs_nxt   = 1'b0;
            w_data_nxt = init_rom(r_idx + 3'd1);
        end else if (r_state == ST_IDLE && w_next_state == ST_SETUP) begin
            w_rs_nxt   = i_wr_rs;
            w_data_nxt = i_wr_data;
        end
        w_e_nxt     = (w_next_state == ST_PULSE);
        w_ready_nxt = (w_next_state == ST_IDLE);
        w_done_nxt  = r_done || (w_next_state == ST_IDLE);
    end

    assign o_wr_ready  = r_ready;
    assign o_init_done = r_done;
    assign o_lcd_rs    = r_rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_e     = r_e;
    assign o_lcd_data  = r_data;
    assign o_state     = r_state;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller using short timing parameters; a pulse
// monitor scores every E strobe against an expected byte queue.
module tb_lcd_controller;
    localparam int P_POWERUP = 20;
    localparam int P_SETUP   = 2;
    localparam int P_PULSE   = 3;
    localparam int P_HOLD    = 1;
    localparam int P_CMD     = 10;
    localparam int P_CLEAR   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    logic [8:0] exp_q[$];
    // Edge (after reset release) at which each init byte is loaded.
    int init_load [6] = '{20, 36, 52, 68, 84, 130};

    lcd_controller #(
        .POWERUP_CYCLES(P_POWERUP), .SETUP_CYCLES(P_SETUP), .E_PULSE_CYCLES(P_PULSE),
        .HOLD_CYCLES(P_HOLD), .CMD_WAIT_CYCLES(P_CMD), .CLEAR_WAIT_CYCLES(P_CLEAR)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_rs(wr_rs),
        .i_wr_data(wr_data), .o_wr_ready(wr_ready), .o_init_done(init_done),
        .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_e(lcd_e),
        .o_lcd_data(lcd_data), .o_state(state)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pulse monitor / scoreboard
    logic       in_pulse = 1'b0;
    int         p_w = 0;
    logic [8:0] p_byte = '0;
    logic [8:0] p_exp;
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else begin
            check("lcd_rw", lcd_rw, 1'b0);
            if (lcd_e && !in_pulse) begin
                in_pulse = 1'b1;
                p_w      = 1;
                p_byte   = {lcd_rs, lcd_data};
            end else if (lcd_e) begin
                p_w++;
                check("pulse_stable", {lcd_rs, lcd_data}, p_byte);
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                n_pulses++;
                check("pulse_hold", {lcd_rs, lcd_data}, p_byte);
                check("pulse_expected", exp_q.size() != 0, 1'b1);
                p_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                check("pulse_byte", p_byte, p_exp);
                check("pulse_width", p_w, P_PULSE);
            end
        end
    end

    // Drivers
    task automatic run_init_check();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
        for (int n = 1; n <= 146; n++) begin
            logic exp_e;
            if (n == 50 || n == 100) begin
                wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hAA;
            end else begin
                wr_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            exp_e = 1'b0;
            for (int j = 0; j < 6; j++)
                if (n >= init_load[j] + 2 && n <= init_load[j] + 4) exp_e = 1'b1;
            check("init_e", lcd_e, exp_e);
            check("init_ready", wr_ready, n >= 146);
            check("init_done", init_done, n >= 146);
        end
        wr_valid = 1'b0;
        check("init_last_data", lcd_data, 8'h06);
        check("init_state_idle", state, 3'd5);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input int wait_len, input bit poke);
        int total;
        total = P_SETUP + P_PULSE + P_HOLD + wait_len;
        wr_valid = 1'b1; wr_rs = rs; wr_data = d;
        exp_q.push_back({rs, d});
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0; wr_rs = ~rs; wr_data = ~d;
        check("acc_rs", lcd_rs, rs);
        check("acc_data", lcd_data, d);
        check("acc_ready", wr_ready, 1'b0);
        for (int m = 1; m <= total; m++) begin
            if (poke && m == 5) begin
                wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
            end else begin
                wr_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("wr_e", lcd_e, m >= 2 && m <= 4);
            check("wr_ready", wr_ready, m == total);
        end
        check("wr_keep_data", lcd_data, d);
        check("wr_keep_rs", lcd_rs, rs);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_ready", wr_ready, 1'b0);
        check("rst_done", init_done, 1'b0);
        check("rst_state", state, 3'd0);
        rst = 1'b0;

        run_init_check();

        // Data write, clear command, ordinary command with busy-time poke
        do_write(1'b1, 8'h41, P_CMD, 1'b0);
        do_write(1'b0, 8'h01, P_CLEAR, 1'b0);
        do_write(1'b0, 8'h80, P_CMD, 1'b1);

        // Held request: ready is back at k+16, so the second accept lands on k+17
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
        exp_q.push_back({1'b1, 8'h41});
        exp_q.push_back({1'b1, 8'h42});
        @(posedge clk);
        @(negedge clk);
        check("held_first_data", lcd_data, 8'h41);
        wr_data = 8'h42;
        for (int m = 1; m <= 17; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (m <= 16) check("held_busy_data", lcd_data, 8'h41);
            if (m == 16) check("held_ready_back", wr_ready, 1'b1);
        end
        check("held_second_data", lcd_data, 8'h42);
        check("held_second_ready", wr_ready, 1'b0);
        wr_valid = 1'b0;
        for (int m = 1; m <= 16; m++) begin
            @(posedge clk);
            @(negedge clk);
            check("held2_ready", wr_ready, m == 16);
        end

        // Reset in the middle of an E pulse
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
        exp_q.push_back({1'b1, 8'h41});
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_e", lcd_e, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_e", lcd_e, 1'b0);
        check("midrst_ready", wr_ready, 1'b0);
        check("midrst_done", init_done, 1'b0);
        check("midrst_data", lcd_data, 8'h00);
        check("midrst_rs", lcd_rs, 1'b0);
        check("midrst_state", state, 3'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_init_check();

        repeat (2) @(negedge clk);
        check("final_pulse_count", n_pulses, 17);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
